// File: rtl/round_timer_pkg.sv
// rtl/round_timer_pkg.sv - shared types and seven-segment table for the round timer
package round_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef logic [3:0] bcd_t;

  // Active-low segment patterns, bit 0 = seg a; entry 0 is the rightmost.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD to active-low seven-segment decode
module bcd_to_seg7
  import round_timer_pkg::*;
(
  input  bcd_t       bcd,
  output logic [6:0] seg
);

  // Codes 10..15 are not digits and blank the display.
  assign seg = (bcd <= 4'd9) ? SEG_TABLE[bcd] : SEG_BLANK;

endmodule

// File: rtl/round_timer.sv
// rtl/round_timer.sv - two-digit BCD countdown driven by counterhz count changes
module round_timer
  import round_timer_pkg::*;
#(
  parameter int START_SECS = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] count_in,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] secs_tens,
  output logic [3:0] secs_ones,
  output logic [6:0] hex_tens,
  output logic [6:0] hex_ones,
  output logic       running,
  output logic       done,
  output logic       expired
);

  if (START_SECS < 1 || START_SECS > 99) begin : g_bad_start_secs
    $error("round_timer: START_SECS must be within 1..99");
  end

  localparam bcd_t START_TENS = bcd_t'(START_SECS / 10);
  localparam bcd_t START_ONES = bcd_t'(START_SECS % 10);

  state_t     state, state_n;
  bcd_t       tens, tens_n;
  bcd_t       ones, ones_n;
  logic [3:0] prev_count;
  logic       expired_q, expired_n;
  logic       tick;

  // Next-state logic: start beats pause beats tick; only RUN consumes ticks.
  always_comb begin
    state_n   = state;
    tens_n    = tens;
    ones_n    = ones;
    expired_n = 1'b0;
    tick      = (count_in != prev_count);
    if (start) begin
      state_n = ST_RUN;
      tens_n  = START_TENS;
      ones_n  = START_ONES;
    end else if (pause) begin
      if (state == ST_RUN) begin
        state_n = ST_PAUSE;
      end else if (state == ST_PAUSE) begin
        state_n = ST_RUN;
      end
    end else if (tick && state == ST_RUN && !(tens == 4'd0 && ones == 4'd0)) begin
      if (ones == 4'd0) begin
        ones_n = 4'd9;
        tens_n = tens - 4'd1;
      end else begin
        ones_n = ones - 4'd1;
      end
      if (tens == 4'd0 && ones == 4'd1) begin
        state_n   = ST_DONE;
        expired_n = 1'b1;
      end
    end
  end

  // State, digit and edge-detect registers; prev_count tracks even in reset.
  always_ff @(posedge clk) begin
    prev_count <= count_in;
    if (!reset_n) begin
      state     <= ST_IDLE;
      tens      <= START_TENS;
      ones      <= START_ONES;
      expired_q <= 1'b0;
    end else begin
      state     <= state_n;
      tens      <= tens_n;
      ones      <= ones_n;
      expired_q <= expired_n;
    end
  end

  assign secs_tens = tens;
  assign secs_ones = ones;
  assign running   = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign expired   = expired_q;

  bcd_to_seg7 u_seg_tens (.bcd(tens), .seg(hex_tens));
  bcd_to_seg7 u_seg_ones (.bcd(ones), .seg(hex_ones));

endmodule

// File: doc/round_timer.md
# round_timer

Downstream consumer of the `counterhz` 4-bit output. It treats every change of that count as one timebase tick and runs a two-digit BCD countdown with start, pause and expiry control. It drives two active-low seven-segment digits and status flags for the game-control logic. The tick rate is set by the `counterhz` speed select, so the same block serves both second-accurate play and slow or fast debug.

## Interface
Parameters:
- `START_SECS`, default 60: countdown reload value in seconds. Legal range 1..99; any other value is an elaboration error.

Ports:
- `clk`  in  1  system clock (CLOCK_50).
- `reset_n`  in  1  reset; synchronous, active-low.
- `count_in`  in  4  free-running count from `counterhz`. Each change of value is one tick.
- `start`  in  1  single-cycle pulse: reload `START_SECS` and run.
- `pause`  in  1  single-cycle pulse: toggle between RUN and PAUSE.
- `secs_tens`  out  4  BCD tens digit, 0..9.
- `secs_ones`  out  4  BCD ones digit, 0..9.
- `hex_tens`  out  7  segments for the tens digit; active-low, bit 0 = seg a.
- `hex_ones`  out  7  segments for the ones digit; same encoding.
- `running`  out  1  high while in RUN.
- `done`  out  1  high while in DONE.
- `expired`  out  1  one-cycle pulse on the transition into DONE.

## Operation
- Tick detect:
  - Register `prev_count`.
  - `tick = (count_in != prev_count)`.
  - `prev_count <= count_in` every cycle, in all states.
  - The 4-bit wrap 15->0 is a change and therefore a tick.
- States: IDLE, RUN, PAUSE, DONE.
- Input priority each cycle: `start` > `pause` > `tick`.
- `start`, in any state: load digits to `START_SECS` (tens, ones) and go to RUN. Any tick in the same cycle is discarded.
- `pause`:
  - RUN -> PAUSE; PAUSE -> RUN.
  - Ignored in IDLE and DONE.
  - A tick in the same cycle is discarded.
- RUN, on tick:
  - Decrement BCD: if ones == 0 then ones = 9 and tens = tens - 1; otherwise ones = ones - 1.
  - If the current value is 01, the result is 00: go to DONE and pulse `expired`.
- IDLE, PAUSE, DONE: ticks are ignored and the digits hold.
- DONE holds 00. Only `start` or reset leaves DONE.
- Underflow below 00 is unreachable. If the digits are 00 in RUN, a tick leaves them unchanged.
- `hex_*` are combinational decodes of the digit registers.

## Timing
- Reset values:
  - state IDLE
  - digits = `START_SECS`
  - `prev_count <= count_in`, so no spurious tick after reset
  - `running` = 0, `done` = 0, `expired` = 0
  - `hex_*` show `START_SECS`
- Tick latency: a `count_in` change visible before edge N updates the digits at edge N. Display latency from a `count_in` change is 1 clock.
- `start`/`pause` take effect on the edge where they are sampled high. `running`/`done` are registered and valid the cycle after.
- `expired` is high for exactly the cycle in which the digits first read 00.
- Reset mid-count: everything returns to the reset values on the next edge. No tick is generated by the reset itself.
- Back-to-back ticks on consecutive cycles (`counterhz` speed 00) each decrement, one per clock.

## Structure
- Package `round_timer_pkg`:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - BCD digit type
  - seven-segment constant table for 0-9, plus blank for illegal codes
- Sub-module `bcd_to_seg7`: purely combinational, 4-bit BCD in, 7-bit active-low out. Values 10..15 give all segments off (7'h7F). Instantiated twice.

## Test plan
- Reset with `START_SECS`=60 -> `secs_tens`=6, `secs_ones`=0, `hex_tens`=7'h02, `hex_ones`=7'h40, `running`=0. Toggling `count_in` for 10 changes leaves the digits at 60.
- `start`, then 15 `count_in` changes -> digits 45 and `running`=1. A change at 10 -> the next change gives 09 (borrow).
- `START_SECS`=3, `start`, 3 changes -> digits 00, `expired` high for one cycle coincident with 00, `done`=1. Further changes keep 00.
- In RUN at 42, `pause` -> 5 changes keep 42. `pause` again -> the next change gives 41.
- `start` and `count_in` change in the same cycle at 17 -> digits reload to `START_SECS`, no decrement. `pause`+tick in the same cycle -> PAUSE with no decrement.
- Assert `reset_n`=0 mid-RUN at 23 with `count_in` changing -> next edge: IDLE, digits = `START_SECS`, no tick in the first cycle after release.
